// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_pkg
// Brief    : Shared FP16 format constants and the stage-1 record of the
//            adder front end (unpack / compare / swap results).
// Revision : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

  // FP16 format widths; the internal mantissa carries the hidden bit
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  // Field positions inside a packed FP16 word
  localparam int c_sign_bit = FP_W - 1;
  localparam int c_exp_hi   = FP_W - 2;
  localparam int c_exp_lo   = MAN_W;
  localparam int c_frac_hi  = MAN_W - 1;
  localparam int c_frac_lo  = 0;

  // Stage-1 record: larger operand L, smaller operand S, shift distance d
  typedef struct packed {
    logic             s_l;
    logic [EXP_W-1:0] e_l;
    logic [MAN_W:0]   m_l;
    logic [MAN_W:0]   m_s;
    logic [EXP_W-1:0] d;
    logic             eff_sub;
  } s1_rec_t;

endpackage : fp_add_pkg
`default_nettype wire

// File: rtl/align_shr.sv
`default_nettype none
// ============================================================================
// Module   : align_shr
// Brief    : Combinational alignment right shifter. Shifts out everything
//            once the distance reaches the operand width.
// Revision : 1.0 - initial release
// ============================================================================
module align_shr #(
  parameter int W  = 11,
  parameter int SW = 5
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  dout
);

  localparam logic [SW-1:0] c_limit = SW'(W);

  // Truncating shift; distances of W or more give zero
  always_comb begin
    dout = '0;
    if (amt < c_limit) begin
      dout = din >> amt;
    end
  end

endmodule : align_shr
`default_nettype wire

// File: rtl/fp16_add_align_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp16_add_align_pipe
// Brief    : Two-stage FP16 adder front end (unpack, compare, swap, align,
//            add/sub) with valid/ready flow control, feeding a normalizer.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_add_align_pipe
  import fp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   op_a,
  input  logic [FP_W-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [MAN_W:0]    mantissa_add,
  output logic              if_carray,
  output logic              if_sub
);

  logic             s1_valid_q, s1_valid_d;
  s1_rec_t          s1_q, s1_d, s1_new;
  logic             out_valid_q, out_valid_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exponent_q, exponent_d;
  logic [MAN_W:0]   mantissa_q, mantissa_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;

  logic             s2_adv, s1_adv;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;
  logic             a_is_l;
  logic [MAN_W:0]   m_s_sh;
  logic [MAN_W+1:0] res12;

  // Pipeline advance: a stage moves when it is empty or its consumer takes it
  always_comb begin
    s2_adv = !out_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready = s1_adv;

  // Stage 1 datapath: flush denormals, pick the larger magnitude (tie -> A)
  always_comb begin
    a_exp  = op_a[c_exp_hi:c_exp_lo];
    b_exp  = op_b[c_exp_hi:c_exp_lo];
    a_man  = (a_exp == '0) ? '0 : {1'b1, op_a[c_frac_hi:c_frac_lo]};
    b_man  = (b_exp == '0) ? '0 : {1'b1, op_b[c_frac_hi:c_frac_lo]};
    a_is_l = (op_a[c_exp_hi:0] >= op_b[c_exp_hi:0]);
    s1_new = '0;
    s1_new.eff_sub = op_a[c_sign_bit] ^ op_b[c_sign_bit];
    if (a_is_l) begin
      s1_new.s_l = op_a[c_sign_bit];
      s1_new.e_l = a_exp;
      s1_new.m_l = a_man;
      s1_new.m_s = b_man;
      s1_new.d   = a_exp - b_exp;
    end else begin
      s1_new.s_l = op_b[c_sign_bit];
      s1_new.e_l = b_exp;
      s1_new.m_l = b_man;
      s1_new.m_s = a_man;
      s1_new.d   = b_exp - a_exp;
    end
  end

  // Stage 1 register load: capture a new record whenever the stage advances
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = s1_new;
      end
    end
  end

  align_shr #(
    .W  (MAN_W + 1),
    .SW (EXP_W)
  ) u_align (
    .din  (s1_q.m_s),
    .amt  (s1_q.d),
    .dout (m_s_sh)
  );

  // Stage 2 datapath: L - S never goes negative because L has the larger magnitude
  always_comb begin
    if (s1_q.eff_sub) begin
      res12 = {1'b0, s1_q.m_l - m_s_sh};
    end else begin
      res12 = {1'b0, s1_q.m_l} + {1'b0, m_s_sh};
    end
  end

  // Stage 2 register load: exact zero results are forced to +0
  always_comb begin
    out_valid_d = out_valid_q;
    sign_d      = sign_q;
    exponent_d  = exponent_q;
    mantissa_d  = mantissa_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (res12 == '0) begin
          sign_d     = 1'b0;
          exponent_d = '0;
          mantissa_d = '0;
          carry_d    = 1'b0;
          sub_d      = 1'b0;
        end else begin
          sign_d     = s1_q.s_l;
          exponent_d = s1_q.e_l;
          mantissa_d = res12[MAN_W:0];
          carry_d    = res12[MAN_W+1];
          sub_d      = s1_q.eff_sub;
        end
      end
    end
  end

  // State registers with synchronous reset clearing both stages
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exponent_q  <= '0;
      mantissa_q  <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      exponent_q  <= exponent_d;
      mantissa_q  <= mantissa_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign sign         = sign_q;
  assign exponent     = exponent_q;
  assign mantissa_add = mantissa_q;
  assign if_carray    = carry_q;
  assign if_sub       = sub_q;

endmodule : fp16_add_align_pipe
`default_nettype wire
